seven_seg_capture: RTL



---
 rtl/seven_seg_capture_if.sv | 21 ++
 rtl/seven_seg_capture.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/seven_seg_capture_if.sv
// Scanned display lines in, rebuilt digits and status flags out.
interface seven_seg_capture_if;
  logic [3:0]  anode;
  logic [6:0]  segment;
  logic [15:0] digits;
  logic [3:0]  valid;
  logic [3:0]  blank;
  logic        frame_done;
  logic        stale;
  logic        anode_error;

  modport master (
    output anode, segment,
    input  digits, valid, blank, frame_done, stale, anode_error
  );

  modport slave (
    input  anode, segment,
    output digits, valid, blank, frame_done, stale, anode_error
  );
endinterface

// File: rtl/seven_seg_capture.sv
// Rebuilds four hex digits from a multiplexed active-low seven-segment scan.
// Latency 1+SETTLE cycles from an anode change to the digit update; no backpressure.
module seven_seg_capture #(
  parameter int SETTLE  = 2,
  parameter int TIMEOUT = 1024
) (
  input  logic               div_clock,
  input  logic               reset,
  seven_seg_capture_if.slave bus
);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, SETTLING, CAPTURED} state_t;

  state_t      state, state_next;
  logic [3:0]  a_q, a_p;
  logic [6:0]  s_q, s_p;
  logic [3:0]  cnt, cnt_next;
  logic [1:0]  idx, idx_next;
  logic [1:0]  a_idx;
  logic        one_hot, multi, latch;
  logic [3:0]  dec_val;
  logic        dec_valid, dec_blank;
  logic [15:0] digits_r;
  logic [3:0]  valid_r, blank_r, seen;
  logic        frame_done_r, anode_error_r;
  logic [TW-1:0] tcnt;

  // a_p/s_p hold the previous registered sample for the stability check
  always_ff @(posedge div_clock or posedge reset) begin
    if (reset) begin
      a_q <= 4'hF;
      s_q <= 7'h7F;
      a_p <= 4'hF;
      s_p <= 7'h7F;
    end else begin
      a_q <= bus.anode;
      s_q <= bus.segment;
      a_p <= a_q;
      s_p <= s_q;
    end
  end

  always_comb begin
    one_hot = 1'b0;
    multi   = 1'b0;
    a_idx   = 2'd0;
    case (a_q)
      4'b1110: begin one_hot = 1'b1; a_idx = 2'd0; end
      4'b1101: begin one_hot = 1'b1; a_idx = 2'd1; end
      4'b1011: begin one_hot = 1'b1; a_idx = 2'd2; end
      4'b0111: begin one_hot = 1'b1; a_idx = 2'd3; end
      4'b1111: ;
      default: multi = 1'b1;
    endcase
  end

  always_ff @(posedge div_clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
      idx   <= 2'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      idx   <= idx_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    idx_next   = idx;
    latch      = 1'b0;
    case (state)
      IDLE: begin
        if (one_hot) begin
          state_next = SETTLING;
          cnt_next   = 4'd1;
          idx_next   = a_idx;
        end
      end
      SETTLING: begin
        if (!one_hot) begin
          state_next = IDLE;
          cnt_next   = 4'd0;
        end else if (a_q == a_p && s_q == s_p) begin
          cnt_next = cnt + 4'd1;
        end else begin
          cnt_next = 4'd1;
          idx_next = a_idx;
        end
      end
      CAPTURED: begin
        if (!one_hot) begin
          state_next = IDLE;
          cnt_next   = 4'd0;
        end else if (a_idx != idx) begin
          state_next = SETTLING;
          cnt_next   = 4'd1;
          idx_next   = a_idx;
        end
      end
      default: state_next = IDLE;
    endcase
    // Covers SETTLE==1, where the entry sample itself completes the settle
    if (state_next == SETTLING && cnt_next == 4'(SETTLE)) begin
      latch      = 1'b1;
      state_next = CAPTURED;
    end
  end

  always_comb begin
    dec_val   = 4'h0;
    dec_valid = 1'b1;
    dec_blank = 1'b0;
    case (s_q)
      7'h40: dec_val = 4'h0;
      7'h79: dec_val = 4'h1;
      7'h24: dec_val = 4'h2;
      7'h30: dec_val = 4'h3;
      7'h19: dec_val = 4'h4;
      7'h12: dec_val = 4'h5;
      7'h02: dec_val = 4'h6;
      7'h78: dec_val = 4'h7;
      7'h00: dec_val = 4'h8;
      7'h10: dec_val = 4'h9;
      7'h08: dec_val = 4'hA;
      7'h03: dec_val = 4'hB;
      7'h46: dec_val = 4'hC;
      7'h21: dec_val = 4'hD;
      7'h06: dec_val = 4'hE;
      7'h0E: dec_val = 4'hF;
      7'h7F: begin dec_valid = 1'b0; dec_blank = 1'b1; end
      default: dec_valid = 1'b0;
    endcase
  end

  always_ff @(posedge div_clock or posedge reset) begin
    if (reset) begin
      digits_r      <= 16'h0000;
      valid_r       <= 4'h0;
      blank_r       <= 4'h0;
      seen          <= 4'h0;
      frame_done_r  <= 1'b0;
      anode_error_r <= 1'b0;
      tcnt          <= '0;
    end else begin
      if (latch) begin
        digits_r[{idx_next, 2'b00} +: 4] <= dec_val;
        valid_r[idx_next]                <= dec_valid;
        blank_r[idx_next]                <= dec_blank;
      end
      // A latch in the clearing cycle starts the next frame's mask
      seen <= ((seen == 4'hF) ? 4'h0 : seen) | (latch ? (4'b0001 << idx_next) : 4'h0);
      frame_done_r <= (seen == 4'hF);
      if (seen == 4'hF)
        tcnt <= '0;
      else if (tcnt != TW'(TIMEOUT))
        tcnt <= tcnt + 1'b1;
      if (multi)
        anode_error_r <= 1'b1;
    end
  end

  assign bus.digits      = digits_r;
  assign bus.valid       = valid_r;
  assign bus.blank       = blank_r;
  assign bus.frame_done  = frame_done_r;
  assign bus.stale       = (tcnt == TW'(TIMEOUT));
  assign bus.anode_error = anode_error_r;
endmodule
